sram_mem_arbiter: RTL and testbench

Parametrised next-generation memory controller. It arbitrates round-robin among NUM_PORTS pipeline requesters (fetch, memory stage, future DMA) for one asynchronous external SRAM. Each request moves one WORD_W word as WORD_W/RAM_W sequential SRAM beats, with byte enables and programmable strobe wait states. It sits between the pipeline stages and the board SRAM pins.

---
 rtl/sram_arb_pkg.sv | 39 +++
 rtl/sram_mem_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sram_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and elaboration-time helpers for the SRAM arbiter.
// Widths depend on the top-level parameters, so they are computed through functions.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StDone
    } state_e;

    // Minimum width is 1 so that single-value counters still have a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    function automatic int unsigned beats_of(input int unsigned word_w, input int unsigned ram_w);
        return word_w / ram_w;
    endfunction

    function automatic int unsigned beat_cnt_w(input int unsigned word_w,
                                               input int unsigned ram_w);
        return clog2_min1(beats_of(word_w, ram_w));
    endfunction

    function automatic int unsigned wait_cnt_w(input int unsigned wait_cycles);
        return clog2_min1(wait_cycles);
    endfunction

    function automatic bit params_ok(input int unsigned word_w, input int unsigned ram_w,
                                     input int unsigned wait_cycles);
        return (ram_w >= 8) && (ram_w % 8 == 0) && (word_w >= ram_w) &&
               (word_w % ram_w == 0) && (wait_cycles >= 1);
    endfunction

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-port packed request/response vectors.
interface sram_mem_arbiter_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned WORD_W    = 32
) ();

    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_rw;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS*WORD_W-1:0]   req_wdata;
    logic [NUM_PORTS*WORD_W/8-1:0] req_be;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS-1:0]          req_done;
    logic [WORD_W-1:0]             req_rdata;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, req_be,
        input  req_ready, req_done, req_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, req_be,
        output req_ready, req_done, req_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 any
);

    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (32'(last_grant) + i + 1) % NUM_PORTS;
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Round-robin controller sharing one asynchronous SRAM among NUM_PORTS requesters;
// each request moves one WORD_W word as WORD_W/RAM_W SETUP+STROBE beats.
module sram_mem_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned RAM_W       = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_mem_arbiter_if.slave    req,
    output logic [ADDR_W-1:0]    ram_addr,
    inout  wire  [RAM_W-1:0]     ram_data,
    output logic                 ram_we_n,
    output logic                 ram_oe_n,
    output logic                 ram_ce_n,
    output logic [RAM_W/8-1:0]   ram_be_n
);

    localparam int unsigned BEATS  = beats_of(WORD_W, RAM_W);
    localparam int unsigned BEAT_W = beat_cnt_w(WORD_W, RAM_W);
    localparam int unsigned WAIT_W = wait_cnt_w(WAIT_CYCLES);
    localparam int unsigned IDX_W  = clog2_min1(NUM_PORTS);
    localparam int unsigned LANES  = RAM_W / 8;

    if (!params_ok(WORD_W, RAM_W, WAIT_CYCLES)) begin : g_param_check
        $error("sram_mem_arbiter: illegal WORD_W/RAM_W/WAIT_CYCLES combination");
    end

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_q, gidx_q;
    logic                 rw_q;
    logic [WORD_W-1:0]    wdata_q, buf_q, rdata_q, rd_word;
    logic [WORD_W/8-1:0]  be_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [ADDR_W-1:0]    addr_q;

    logic [NUM_PORTS-1:0] arb_grant, ready, done;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any, accept, beat_end, last_beat, busy;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .valid      (req.req_valid),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        beat_end = 1'b0;
        ready    = '0;
        done     = '0;
        unique case (state_q)
            StIdle: begin
                // Gated by reset so no acceptance pulse leaks out while held in reset.
                if (arb_any && reset) begin
                    accept  = 1'b1;
                    ready   = arb_grant;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    beat_end = 1'b1;
                    state_d  = last_beat ? StDone : StSetup;
                end
            end
            StDone: begin
                done[gidx_q] = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // The final beat lands straight in rdata_q so the word changes only on entry to DONE.
    always_comb begin
        rd_word = buf_q;
        rd_word[beat_q*RAM_W +: RAM_W] = ram_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q  <= IDX_W'(NUM_PORTS - 1);
            gidx_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                last_q  <= arb_idx;
                gidx_q  <= arb_idx;
                rw_q    <= req.req_rw[arb_idx];
                addr_q  <= req.req_addr[arb_idx*ADDR_W +: ADDR_W];
                wdata_q <= req.req_wdata[arb_idx*WORD_W +: WORD_W];
                be_q    <= req.req_be[arb_idx*(WORD_W/8) +: WORD_W/8];
                beat_q  <= '0;
                wait_q  <= '0;
            end
            if (state_q == StStrobe) begin
                if (beat_end) begin
                    wait_q <= '0;
                    if (!rw_q) begin
                        if (last_beat) rdata_q <= rd_word;
                        else           buf_q[beat_q*RAM_W +: RAM_W] <= ram_data;
                    end
                    if (!last_beat) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end else begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
            end
        end
    end

    assign busy          = (state_q == StSetup) || (state_q == StStrobe);
    assign ram_addr      = addr_q;
    assign ram_ce_n      = !busy;
    assign ram_we_n      = !((state_q == StStrobe) && rw_q);
    assign ram_oe_n      = !((state_q == StStrobe) && !rw_q);
    assign ram_be_n      = !busy ? '1 : (rw_q ? ~be_q[beat_q*LANES +: LANES] : '0);
    assign ram_data      = (busy && rw_q) ? wdata_q[beat_q*RAM_W +: RAM_W] : {RAM_W{1'bz}};
    assign req.req_ready = ready;
    assign req.req_done  = done;
    assign req.req_rdata = rdata_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed bench for sram_mem_arbiter: default instance plus a WAIT_CYCLES=3 instance,
// each driving a behavioural asynchronous SRAM.
module tb_sram_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    sram_mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(18), .WORD_W(32)) bus  ();
    sram_mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(18), .WORD_W(32)) bus3 ();

    logic [17:0] ram_addr, ram3_addr;
    wire  [15:0] ram_data, ram3_data;
    logic        ram_we_n, ram_oe_n, ram_ce_n, ram3_we_n, ram3_oe_n, ram3_ce_n;
    logic [1:0]  ram_be_n, ram3_be_n;

    sram_mem_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .req      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we_n (ram_we_n),
        .ram_oe_n (ram_oe_n),
        .ram_ce_n (ram_ce_n),
        .ram_be_n (ram_be_n)
    );

    sram_mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clock    (clock),
        .reset    (reset),
        .req      (bus3),
        .ram_addr (ram3_addr),
        .ram_data (ram3_data),
        .ram_we_n (ram3_we_n),
        .ram_oe_n (ram3_oe_n),
        .ram_ce_n (ram3_ce_n),
        .ram_be_n (ram3_be_n)
    );

    // Behavioural SRAMs; preloaded through the poke port so each array has one writer.
    logic [15:0] mem  [0:262143];
    logic [15:0] mem3 [0:262143];
    logic        poke_en = 1'b0, poke_sel = 1'b0;
    logic [17:0] poke_addr = '0;
    logic [15:0] poke_data = '0;

    assign ram_data  = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr] : 16'hzzzz;
    assign ram3_data = (!ram3_ce_n && !ram3_oe_n && ram3_we_n) ? mem3[ram3_addr] : 16'hzzzz;

    always @(posedge clock) begin
        if (poke_en && !poke_sel) mem[poke_addr]  <= poke_data;
        if (poke_en && poke_sel)  mem3[poke_addr] <= poke_data;
        if (!ram_ce_n && !ram_we_n) begin
            if (!ram_be_n[0]) mem[ram_addr][7:0]  <= ram_data[7:0];
            if (!ram_be_n[1]) mem[ram_addr][15:8] <= ram_data[15:8];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic sel, input logic [17:0] a, input logic [15:0] d);
        poke_sel  = sel;
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int grant_idx [4];
    int grant_cyc [4];
    int ng, done_at, oe_low;
    logic seen;

    initial begin
        bus.req_valid  = '0; bus.req_rw  = '0; bus.req_addr  = '0; bus.req_wdata  = '0;
        bus.req_be     = '0;
        bus3.req_valid = '0; bus3.req_rw = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
        bus3.req_be    = '0;
        poke(1'b0, 18'h00010, 16'h1234);
        poke(1'b0, 18'h00011, 16'hABCD);
        poke(1'b0, 18'h00020, 16'h1111);
        poke(1'b0, 18'h00021, 16'h2222);
        poke(1'b0, 18'h3FFFF, 16'h7777);
        poke(1'b0, 18'h00000, 16'h8888);
        poke(1'b1, 18'h00040, 16'h5555);
        poke(1'b1, 18'h00041, 16'h6666);

        // Reset state
        check_eq("rst_ce_n",  ram_ce_n, 1);
        check_eq("rst_we_oe", {ram_we_n, ram_oe_n}, 2'b11);
        check_eq("rst_be_n",  ram_be_n, 2'b11);
        check_eq("rst_addr",  ram_addr, 0);
        check_eq("rst_z",     ram_data === 16'hzzzz, 1);
        check_eq("rst_rdy_done", {bus.req_ready, bus.req_done}, 0);
        check_eq("rst_rdata", bus.req_rdata, 0);
        reset = 1'b1;
        tick();

        // Read, default timing
        bus.req_rw = 2'b00; bus.req_addr = {18'h0, 18'h00010}; bus.req_valid = 2'b01;
        #1;
        check_eq("rd_ready", bus.req_ready, 2'b01);
        tick(); bus.req_valid = 2'b00;
        check_eq("rd_setup", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b011);
        tick();
        check_eq("rd_strobe0", {ram_oe_n, ram_addr}, {1'b0, 18'h00010});
        check_eq("rd_be_n", ram_be_n, 2'b00);
        tick();
        check_eq("rd_setup1", {ram_oe_n, ram_addr}, {1'b1, 18'h00011});
        tick();
        check_eq("rd_strobe1", ram_oe_n, 0);
        tick();
        check_eq("rd_done", bus.req_done, 2'b01);
        check_eq("rd_rdata", bus.req_rdata, 32'hABCD1234);
        check_eq("rd_done_ce", ram_ce_n, 1);
        tick();

        // Write with byte enables, port 1
        bus.req_rw = 2'b10; bus.req_addr = {18'h00020, 18'h0};
        bus.req_wdata = {32'hDEADBEEF, 32'h0}; bus.req_be = {4'b0110, 4'b0000};
        bus.req_valid = 2'b10;
        #1;
        check_eq("wr_ready", bus.req_ready, 2'b10);
        tick(); bus.req_valid = 2'b00;
        check_eq("wr_setup0", {ram_we_n, ram_be_n, ram_data}, {1'b1, 2'b01, 16'hBEEF});
        tick();
        check_eq("wr_strobe0", {ram_we_n, ram_oe_n, ram_data}, {1'b0, 1'b1, 16'hBEEF});
        tick();
        check_eq("wr_setup1", {ram_be_n, ram_data, ram_addr}, {2'b10, 16'hDEAD, 18'h00021});
        tick();
        check_eq("wr_strobe1", ram_we_n, 0);
        tick();
        check_eq("wr_done", bus.req_done, 2'b10);
        check_eq("wr_done_z", ram_data === 16'hzzzz, 1);
        check_eq("wr_mem20", mem[18'h00020], 16'hBE11);
        check_eq("wr_mem21", mem[18'h00021], 16'h22AD);
        check_eq("wr_rdata_held", bus.req_rdata, 32'hABCD1234);
        tick();

        // Contention: both ports hold valid
        bus.req_rw = 2'b00; bus.req_addr = {18'h00100, 18'h00200}; bus.req_valid = 2'b11;
        #1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            if (bus.req_ready != 2'b00) begin
                grant_idx[ng] = (bus.req_ready == 2'b01) ? 0 : (bus.req_ready == 2'b10) ? 1 : 9;
                grant_cyc[ng] = c;
                ng++;
            end
            tick();
        end
        bus.req_valid = 2'b00;
        check_eq("ct_count", ng, 4);
        check_eq("ct_order", {grant_idx[0][3:0], grant_idx[1][3:0], grant_idx[2][3:0],
                              grant_idx[3][3:0]}, 16'h0101);
        for (int k = 1; k < 4; k++)
            check_eq("ct_spacing", grant_cyc[k] - grant_cyc[k-1], 6);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_done == 2'b10) begin seen = 1'b1; break; end
            tick();
        end
        check_eq("ct_drain", seen, 1);
        tick();

        // Wait states on the WAIT_CYCLES=3 instance
        bus3.req_rw = 2'b00; bus3.req_addr = {18'h0, 18'h00040}; bus3.req_valid = 2'b01;
        #1;
        check_eq("ws_ready", bus3.req_ready, 2'b01);
        done_at = -1; oe_low = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) bus3.req_valid = 2'b00;
            if (!ram3_oe_n) oe_low++;
            if (bus3.req_done != 2'b00) begin done_at = k; break; end
        end
        check_eq("ws_done_at", done_at, 9);
        check_eq("ws_oe_low", oe_low, 6);
        check_eq("ws_rdata", bus3.req_rdata, 32'h66665555);
        tick();

        // Address wrap within a transaction
        bus.req_rw = 2'b00; bus.req_addr = {18'h0, 18'h3FFFF}; bus.req_valid = 2'b01;
        #1;
        check_eq("wrap_ready", bus.req_ready, 2'b01);
        tick(); bus.req_valid = 2'b00;
        tick();
        check_eq("wrap_addr0", ram_addr, 18'h3FFFF);
        tick();
        check_eq("wrap_addr1", ram_addr, 18'h00000);
        tick(); tick();
        check_eq("wrap_done", bus.req_done, 2'b01);
        check_eq("wrap_rdata", bus.req_rdata, 32'h88887777);
        tick();

        // Reset during STROBE of a write
        bus.req_rw = 2'b10; bus.req_addr = {18'h00030, 18'h00050};
        bus.req_wdata = {32'h01020304, 32'h0}; bus.req_be = {4'b1111, 4'b0000};
        bus.req_valid = 2'b10;
        #1;
        check_eq("ra_ready", bus.req_ready, 2'b10);
        tick();
        tick();
        check_eq("ra_in_strobe", ram_we_n, 0);
        bus.req_valid = 2'b11;
        reset = 1'b0;
        #1;
        check_eq("ra_strobes", {ram_ce_n, ram_we_n, ram_oe_n}, 3'b111);
        check_eq("ra_z", ram_data === 16'hzzzz, 1);
        check_eq("ra_no_done", bus.req_done, 2'b00);
        check_eq("ra_no_ready", bus.req_ready, 2'b00);
        check_eq("ra_rdata", bus.req_rdata, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("ra_port0_first", bus.req_ready, 2'b01);
        tick(); bus.req_valid = 2'b00;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_done != 2'b00) begin seen = 1'b1; break; end
            tick();
        end
        check_eq("ra_after_done", {seen, bus.req_done}, {1'b1, 2'b01});
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
